bft_traffic_gen: RTL and testbench

- Parametrised, synthesizable traffic generator and checker for the bft wishbone-side interface.
- Drives bursts of patterned input words with configurable length, gap, count and pattern, honouring a `ready` backpressure input.
- Controls the output-read window and checks returned words against an independently regenerated expected sequence, counting mismatches.
- Used for on-chip BIST and as a reusable bench driver for bft and its loopback/bypass configurations.

---
 rtl/bft_traffic_gen_if.sv | 39 +++
 rtl/bft_traffic_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_bft_traffic_gen.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bft_traffic_gen_if.sv
// Bus between the traffic generator and the bft wishbone-side ports.
//   wbDataForInput  : generator -> bft, input word valid
//   wbInputData     : generator -> bft, input word
//   ready           : bft -> generator, word accepted this cycle when valid
//   wbWriteOut      : generator -> bft, read-out window enable
//   wbDataForOutput : bft -> generator, returned word valid
//   wbOutputData    : bft -> generator, returned word
//   dutError        : bft -> generator, error flag
interface bft_traffic_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wbDataForInput;
    logic [DATA_WIDTH-1:0] wbInputData;
    logic                  ready;
    logic                  wbWriteOut;
    logic                  wbDataForOutput;
    logic [DATA_WIDTH-1:0] wbOutputData;
    logic                  dutError;

    modport master (
        output wbDataForInput,
        output wbInputData,
        output wbWriteOut,
        input  ready,
        input  wbDataForOutput,
        input  wbOutputData,
        input  dutError
    );

    modport slave (
        input  wbDataForInput,
        input  wbInputData,
        input  wbWriteOut,
        output ready,
        output wbDataForOutput,
        output wbOutputData,
        output dutError
    );
endinterface

// File: rtl/bft_traffic_gen.sv
// Traffic generator and checker for the bft wishbone-side interface.
// Sends NUM_BURSTS bursts of BURST_LEN patterned words (GAP_CYCLES idle cycles
// before each), opens the read-out window after the first burst, and compares
// every returned word against an independently advanced copy of the pattern.
//
// Ports:
//   wbClk     : clock, rising edge
//   resetN    : asynchronous active-low reset
//   start     : one-cycle run request, honoured in IDLE or DONE
//   mode      : pattern select (0 dec, 1 inc, 2 LFSR, 3 constant), sampled on start
//   busy      : run in progress (GAP/BURST/DRAIN)
//   done      : run complete, held until next start
//   error     : sticky error (mismatch, dutError, overrun, drain timeout)
//   errCount  : saturating mismatch count
//   burstCnt  : completed bursts in current run
//   bus       : master side of bft_traffic_gen_if
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset, waiting for start
// GAP    | idle cycles before a burst (at least one)
// BURST  | presenting words, advancing on valid & ready
// DRAIN  | all bursts sent, waiting for remaining returned words
// DONE   | run finished, done held, waiting for start
module bft_traffic_gen #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    BURST_LEN     = 16,
    parameter int                    GAP_CYCLES    = 26,
    parameter int                    NUM_BURSTS    = 100,
    parameter logic [DATA_WIDTH-1:0] SEED          = '0,
    parameter int                    DRAIN_TIMEOUT = 1024
) (
    input  logic                      wbClk,
    input  logic                      resetN,
    input  logic                      start,
    input  logic [1:0]                mode,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [15:0]               errCount,
    output logic [15:0]               burstCnt,
    bft_traffic_gen_if.master         bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GAP   = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_LFSR = 2'd2;

    // GAP_CYCLES = 0 still spends one cycle in GAP, hence the clamp.
    localparam int GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W     = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;
    localparam int WORD_LOAD = (BURST_LEN > 0) ? BURST_LEN - 1 : 0;
    localparam int WORD_W    = (WORD_LOAD > 0) ? $clog2(WORD_LOAD + 1) : 1;
    localparam int DRN_LOAD  = (DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0;
    localparam int DRN_W     = (DRN_LOAD > 0) ? $clog2(DRN_LOAD + 1) : 1;

    localparam logic [31:0]           TOTAL_WORDS = 32'(BURST_LEN * NUM_BURSTS);
    localparam logic [15:0]           BURSTS_LAST = 16'(NUM_BURSTS);
    localparam logic [DATA_WIDTH-1:0] ONE         = DATA_WIDTH'(1);

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [1:0] m,
                                                      input logic [DATA_WIDTH-1:0] p);
        case (m)
            2'd0:    return p - ONE;
            2'd1:    return p + ONE;
            2'd2:    return {p[DATA_WIDTH-2:0], p[DATA_WIDTH-1] ^ p[DATA_WIDTH-2]};
            default: return p;
        endcase
    endfunction

    logic [2:0]            state_q,   state_d;
    logic [1:0]            mode_q,    mode_d;
    logic [DATA_WIDTH-1:0] gen_q,     gen_d;
    logic [DATA_WIDTH-1:0] exp_q,     exp_d;
    logic [GAP_W-1:0]      gap_q,     gap_d;
    logic [WORD_W-1:0]     word_q,    word_d;
    logic [DRN_W-1:0]      drn_q,     drn_d;
    logic [15:0]           burst_q,   burst_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic                  err_q,     err_d;
    logic                  wr_out_q,  wr_out_d;
    logic [31:0]           rx_q,      rx_d;

    logic                  busy_w;
    logic [DATA_WIDTH-1:0] seed_w;

    assign busy_w = (state_q == S_GAP) || (state_q == S_BURST) || (state_q == S_DRAIN);
    // An all-zero LFSR would never leave zero.
    assign seed_w = ((mode == M_LFSR) && (SEED == '0)) ? ONE : SEED;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        gen_d     = gen_q;
        exp_d     = exp_q;
        gap_d     = gap_q;
        word_d    = word_q;
        drn_d     = drn_q;
        burst_d   = burst_q;
        err_cnt_d = err_cnt_q;
        err_d     = err_q;
        wr_out_d  = wr_out_q;
        rx_d      = rx_q;

        // Checker runs independently of the sending side whenever a run is active.
        if (busy_w && bus.wbDataForOutput) begin
            rx_d  = rx_q + 32'd1;
            exp_d = advance(mode_q, exp_q);
            if (bus.wbOutputData != exp_q) begin
                err_d = 1'b1;
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            if (rx_q >= TOTAL_WORDS) begin
                err_d = 1'b1;
            end
        end

        if (busy_w && bus.dutError) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_GAP;
                    mode_d    = mode;
                    gen_d     = seed_w;
                    exp_d     = seed_w;
                    gap_d     = GAP_W'(GAP_LOAD);
                    word_d    = '0;
                    burst_d   = '0;
                    err_cnt_d = '0;
                    err_d     = 1'b0;
                    wr_out_d  = 1'b0;
                    rx_d      = '0;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_BURST;
                    word_d  = WORD_W'(WORD_LOAD);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_BURST: begin
                if (bus.ready) begin
                    gen_d = advance(mode_q, gen_q);
                    if (word_q == '0) begin
                        burst_d  = burst_q + 16'd1;
                        wr_out_d = 1'b1;
                        if ((burst_q + 16'd1) == BURSTS_LAST) begin
                            state_d = S_DRAIN;
                            drn_d   = DRN_W'(DRN_LOAD);
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GAP_W'(GAP_LOAD);
                        end
                    end else begin
                        word_d = word_q - WORD_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Final receipt is checked before the timeout so it wins a tie.
                if (rx_d >= TOTAL_WORDS) begin
                    state_d  = S_DONE;
                    wr_out_d = 1'b0;
                end else if (drn_q == '0) begin
                    state_d  = S_DONE;
                    wr_out_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wbClk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            gen_q     <= '0;
            exp_q     <= '0;
            gap_q     <= '0;
            word_q    <= '0;
            drn_q     <= '0;
            burst_q   <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            wr_out_q  <= 1'b0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            gen_q     <= gen_d;
            exp_q     <= exp_d;
            gap_q     <= gap_d;
            word_q    <= word_d;
            drn_q     <= drn_d;
            burst_q   <= burst_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            wr_out_q  <= wr_out_d;
            rx_q      <= rx_d;
        end
    end

    assign bus.wbDataForInput = (state_q == S_BURST);
    assign bus.wbInputData    = gen_q;
    assign bus.wbWriteOut     = wr_out_q;
    assign busy               = busy_w;
    assign done               = (state_q == S_DONE);
    assign error              = err_q;
    assign errCount           = err_cnt_q;
    assign burstCnt           = burst_q;

endmodule

// File: tb/tb_bft_traffic_gen.sv
module tb_bft_traffic_gen;
    localparam int DW    = 32;
    localparam int BL    = 4;
    localparam int NB    = 2;
    localparam int GAP   = 2;
    localparam int DT    = 40;
    localparam int TOTAL = BL * NB;

    logic        wbClk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        busy, done, error;
    logic [15:0] errCount, burstCnt;

    bft_traffic_gen_if #(.DATA_WIDTH(DW)) bus ();

    bft_traffic_gen #(
        .DATA_WIDTH(DW), .BURST_LEN(BL), .GAP_CYCLES(GAP), .NUM_BURSTS(NB),
        .SEED(32'h0), .DRAIN_TIMEOUT(DT)
    ) dut (
        .wbClk(wbClk), .resetN(resetN), .start(start), .mode(mode),
        .busy(busy), .done(done), .error(error),
        .errCount(errCount), .burstCnt(burstCnt), .bus(bus.master)
    );

    always #5 wbClk = ~wbClk;

    int total = 0;
    int bad = 0;

    // environment / model state
    logic [31:0] xq[$];
    int          xfers, hold_err, wr_first, tick_no, last_xfer_tick, done_tick;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        pipe_v[3];
    logic [31:0] pipe_d[3];
    bit          loop_en;
    int          corrupt_idx, rdy_mode, stall_left, pulse_at, derr_at;
    bit          pulsed, derr_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat_next(input logic [1:0] m, input logic [31:0] p);
        case (m)
            2'd0:    return p - 32'd1;
            2'd1:    return p + 32'd1;
            2'd2:    return (p << 1) | (((p >> 31) ^ (p >> 30)) & 32'd1);
            default: return p;
        endcase
    endfunction

    task automatic chk_words(input logic [1:0] m);
        logic [31:0] e;
        e = (m == 2'd2) ? 32'd1 : 32'd0;
        chk("word_count", xq.size(), TOTAL);
        for (int i = 0; i < xq.size() && i < TOTAL; i++) begin
            chk($sformatf("word%0d", i), xq[i], e);
            e = pat_next(m, e);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 3; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
    endtask

    // One cycle: observe at the falling edge, then drive inputs for the next rising edge.
    task automatic tick();
        logic        r, v;
        logic [31:0] d;
        @(negedge wbClk);
        tick_no++;
        v = bus.wbDataForInput;
        d = bus.wbInputData;
        if (wr_first < 0 && bus.wbWriteOut) wr_first = xfers;
        if (prev_stall && !(v && d == prev_data)) hold_err++;
        case (rdy_mode)
            0: r = 1'b1;
            1: r = ($urandom_range(0, 9) < 7);
            default: begin
                if (xfers == 2 && stall_left > 0) begin
                    r = 1'b0;
                    stall_left--;
                end else begin
                    r = 1'b1;
                end
            end
        endcase
        bus.ready = r;
        prev_stall = v && !r;
        prev_data = d;
        bus.wbDataForOutput = pipe_v[2];
        bus.wbOutputData = pipe_d[2];
        pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
        pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
        pipe_v[0] = v && r && loop_en;
        pipe_d[0] = d ^ ((xfers == corrupt_idx) ? 32'd1 : 32'd0);
        if (v && r) begin
            xq.push_back(d);
            xfers++;
            last_xfer_tick = tick_no;
        end
        start = 1'b0;
        if (pulse_at >= 0 && xfers == pulse_at && !pulsed) begin
            start = 1'b1;
            mode = 2'd3;
            pulsed = 1'b1;
        end
        bus.dutError = 1'b0;
        if (derr_at >= 0 && xfers == derr_at && !derr_done) begin
            bus.dutError = 1'b1;
            derr_done = 1'b1;
        end
    endtask

    task automatic run(input logic [1:0] m, input int budget);
        xq.delete();
        xfers = 0; wr_first = -1; hold_err = 0; prev_stall = 1'b0;
        pulsed = 1'b0; derr_done = 1'b0;
        mode = m;
        start = 1'b1;
        tick();
        chk("run_busy", 32'(busy), 32'd1);
        for (int i = 0; i < budget && !done; i++) tick();
        done_tick = tick_no;
        chk("run_finished", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] rm;
        bit         exp_err;
        bus.ready = 1'b0; bus.wbDataForOutput = 1'b0; bus.wbOutputData = '0; bus.dutError = 1'b0;
        clear_pipe();
        loop_en = 1'b1; corrupt_idx = -1; rdy_mode = 0; stall_left = 0;
        pulse_at = -1; derr_at = -1; tick_no = 0; xfers = 0; last_xfer_tick = 0;
        wr_first = -1; hold_err = 0; prev_stall = 1'b0; prev_data = '0;

        // reset state
        resetN = 1'b0;
        repeat (3) tick();
        chk("rst_flags", {27'd0, busy, done, error, bus.wbDataForInput, bus.wbWriteOut}, 32'd0);
        chk("rst_errCount", 32'(errCount), 32'd0);
        chk("rst_burstCnt", 32'(burstCnt), 32'd0);
        chk("rst_data", bus.wbInputData, 32'd0);
        resetN = 1'b1;
        repeat (2) tick();

        // decrement, clean loopback, full ready
        run(2'd0, 500);
        chk_words(2'd0);
        chk("dec_errCount", 32'(errCount), 32'd0);
        chk("dec_error", 32'(error), 32'd0);
        chk("dec_burstCnt", 32'(burstCnt), NB);
        chk("dec_wrout_first", wr_first, BL);
        chk("dec_wrout_done", 32'(bus.wbWriteOut), 32'd0);
        // dutError outside a run is ignored
        bus.dutError = 1'b1;
        tick();
        tick();
        chk("idle_duterr", 32'(error), 32'd0);
        chk("done_held", 32'(done), 32'd1);

        // ready low for two cycles mid-burst
        rdy_mode = 2; stall_left = 2;
        run(2'd0, 500);
        chk_words(2'd0);
        chk("stall_hold", hold_err, 0);
        chk("stall_used", stall_left, 0);
        chk("stall_errCount", 32'(errCount), 32'd0);

        // corrupted returned word
        rdy_mode = 0; corrupt_idx = 5;
        run(2'd0, 500);
        chk("corrupt_errCount", 32'(errCount), 32'd1);
        chk("corrupt_error", 32'(error), 32'd1);
        chk("corrupt_words", xq.size(), TOTAL);
        corrupt_idx = -1;

        // nothing returned: drain timeout
        loop_en = 1'b0;
        run(2'd0, 500);
        chk("to_error", 32'(error), 32'd1);
        chk("to_errCount", 32'(errCount), 32'd0);
        chk("to_drain_cycles", done_tick - last_xfer_tick, DT + 1);
        loop_en = 1'b1;

        // LFSR from zero seed, random backpressure, start pulsed while busy
        rdy_mode = 1; pulse_at = 3;
        run(2'd2, 500);
        chk("lfsr_pulsed", 32'(pulsed), 32'd1);
        chk("lfsr_w0", xq.size() > 0 ? xq[0] : 32'hDEAD, 32'd1);
        chk("lfsr_w3", xq.size() > 3 ? xq[3] : 32'hDEAD, 32'd8);
        chk_words(2'd2);
        chk("lfsr_burstCnt", 32'(burstCnt), NB);
        chk("lfsr_errCount", 32'(errCount), 32'd0);
        chk("lfsr_hold", hold_err, 0);
        pulse_at = -1;

        // randomized runs
        for (int k = 0; k < 5; k++) begin
            rm = 2'($urandom_range(0, 3));
            rdy_mode = 1;
            corrupt_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, TOTAL - 1)) : -1;
            derr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TOTAL - 1)) : -1;
            exp_err = (corrupt_idx >= 0) || (derr_at >= 0);
            run(rm, 800);
            chk_words(rm);
            chk($sformatf("rnd%0d_errCount", k), 32'(errCount), (corrupt_idx >= 0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_error", k), 32'(error), 32'(exp_err));
            chk($sformatf("rnd%0d_hold", k), hold_err, 0);
            chk($sformatf("rnd%0d_burstCnt", k), 32'(burstCnt), NB);
        end
        corrupt_idx = -1; derr_at = -1; rdy_mode = 0;

        // reset in the middle of a burst
        xq.delete(); xfers = 0;
        mode = 2'd0;
        start = 1'b1;
        for (int i = 0; i < 60 && xfers < 2; i++) tick();
        chk("mid_reached", xfers, 2);
        resetN = 1'b0;
        #1;
        chk("mid_rst_flags", {27'd0, busy, done, error, bus.wbDataForInput, bus.wbWriteOut}, 32'd0);
        chk("mid_rst_data", bus.wbInputData, 32'd0);
        chk("mid_rst_burstCnt", 32'(burstCnt), 32'd0);
        clear_pipe();
        repeat (2) tick();
        clear_pipe();
        resetN = 1'b1;
        tick();
        run(2'd0, 500);
        chk_words(2'd0);
        chk("post_rst_errCount", 32'(errCount), 32'd0);
        chk("post_rst_error", 32'(error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
